// File: rtl/usb3300_transmitter.sv
// ULPI link-side transmitter for the USB3300: sends TX CMD + two data bytes, then STP.
// All outputs are registered from the next-state decision, so nothing combinational reaches a pin.
//
// state | meaning
// IDLE  | bus idle, waiting for start
// TXCMD | presenting TX CMD {0100,PID}; yields to the PHY while DIR is high
// BYTE1 | presenting D1 until NXT
// BYTE2 | presenting D2 until NXT
// STOP  | one cycle of STP with 00, normal completion
// ABORT | PHY took the bus mid-packet; wait for DIR low
// TERM  | NXT timeout, one cycle of STP with FF
module usb3300_transmitter #(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] PID,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic       DIR,
  input  logic       NXT,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       STP,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [15:0] TMO = 16'(NXT_TIMEOUT);

  typedef enum logic [2:0] {IDLE, TXCMD, BYTE1, BYTE2, STOP, ABORT, TERM} state_t;

  state_t      state, state_n;
  logic [3:0]  pid_q, pid_n;
  logic [7:0]  d1_q, d1_n, d2_q, d2_n;
  logic [15:0] cnt, cnt_n;
  logic        dir_q;
  logic        waiting, timeout_hit;

  logic [7:0]  data_out_n;
  logic        oe_n, stp_n, busy_n, done_n, err_n;

  logic        unused_pid_hi;
  assign unused_pid_hi = ^PID[7:4];

  assign waiting     = (state == TXCMD) || (state == BYTE1) || (state == BYTE2);
  assign timeout_hit = (cnt + 16'd1) == TMO;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pid_q    <= 4'h0;
      d1_q     <= 8'h00;
      d2_q     <= 8'h00;
      cnt      <= 16'h0000;
      dir_q    <= 1'b0;
      DATA_OUT <= 8'h00;
      DATA_OE  <= 1'b1;
      STP      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pid_q    <= pid_n;
      d1_q     <= d1_n;
      d2_q     <= d2_n;
      cnt      <= cnt_n;
      dir_q    <= DIR;
      DATA_OUT <= data_out_n;
      DATA_OE  <= oe_n;
      STP      <= stp_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    pid_n   = pid_q;
    d1_n    = d1_q;
    d2_n    = d2_q;
    unique case (state)
      IDLE: begin
        if (start && !DIR && !dir_q) begin
          state_n = TXCMD;
          pid_n   = PID[3:0];
          d1_n    = D1;
          d2_n    = D2;
        end
      end
      // NXT only counts once the bus has actually been driven for a full cycle
      TXCMD: begin
        if (!DIR) begin
          if (NXT && DATA_OE)           state_n = BYTE1;
          else if (!NXT && timeout_hit) state_n = TERM;
        end
      end
      BYTE1: begin
        if (DIR)              state_n = ABORT;
        else if (NXT)         state_n = BYTE2;
        else if (timeout_hit) state_n = TERM;
      end
      BYTE2: begin
        if (DIR)              state_n = ABORT;
        else if (NXT)         state_n = STOP;
        else if (timeout_hit) state_n = TERM;
      end
      STOP:    state_n = IDLE;
      TERM:    state_n = IDLE;
      ABORT:   if (!DIR) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if ((state_n != state) || NXT) cnt_n = 16'h0000;
    else if (waiting && !DIR)      cnt_n = cnt + 16'd1;
    else                           cnt_n = cnt;
  end

  always_comb begin
    data_out_n = 8'h00;
    oe_n       = !(DIR || dir_q);
    stp_n      = 1'b0;
    busy_n     = (state_n != IDLE);
    done_n     = (state == STOP) && (state_n == IDLE);
    err_n      = (state_n == TERM) || ((state_n == ABORT) && (state != ABORT));
    unique case (state_n)
      TXCMD:   data_out_n = {4'b0100, pid_n};
      BYTE1:   data_out_n = d1_n;
      BYTE2:   data_out_n = d2_n;
      STOP:    stp_n = 1'b1;
      ABORT:   oe_n = 1'b0;
      TERM: begin
        stp_n      = 1'b1;
        data_out_n = 8'hFF;
      end
      default: data_out_n = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_usb3300_transmitter.sv
// Randomized PHY-side bench for usb3300_transmitter with an event scoreboard.
// Events: 1=byte accepted, 2=STP cycle (value = DATA_OUT), 3=done, 4=err.
module tb_usb3300_transmitter;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] PID = 8'h00, D1 = 8'h00, D2 = 8'h00;
  logic       DIR = 1'b0, NXT = 1'b0;
  logic [7:0] DATA_OUT;
  logic       DATA_OE, STP, busy, done, err;

  usb3300_transmitter #(.NXT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .PID(PID), .D1(D1), .D2(D2),
    .DIR(DIR), .NXT(NXT), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .STP(STP), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int expq[$];
  logic oe_seen, busy_seen;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic observe(input int ev);
    if (expq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %0h, expected no event (t=%0t)", ev, $time);
    end else begin
      check("event", ev, expq.pop_front());
    end
  endtask

  // Reference: what the PHY should see for a packet ending in the given way.
  // kind 0 = completes, 1 = PHY abort at stage, 2 = timeout at stage (stage 0=TXCMD,1=D1,2=D2)
  function automatic void push_pkt(input logic [7:0] p, input logic [7:0] a,
                                   input logic [7:0] b, input int kind, input int stage);
    int bytes[3];
    int n;
    bytes[0] = 32'h40 + int'(p[3:0]);
    bytes[1] = int'(a);
    bytes[2] = int'(b);
    n = (kind == 0) ? 3 : stage;
    for (int i = 0; i < n; i++) expq.push_back(32'h100 + bytes[i]);
    if (kind == 0) begin
      expq.push_back(32'h200);
      expq.push_back(32'h300);
    end else if (kind == 1) begin
      expq.push_back(32'h400);
    end else begin
      expq.push_back(32'h2FF);
      expq.push_back(32'h400);
    end
  endfunction

  logic [7:0] prev_out;
  logic       prev_hold = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && busy && DATA_OE && !STP && !err)
        check("byte_hold", int'(DATA_OUT), int'(prev_out));
      if (NXT && !DIR && DATA_OE && busy && !STP) observe(32'h100 + int'(DATA_OUT));
      if (STP)  observe(32'h200 + int'(DATA_OUT));
      if (done) observe(32'h300);
      if (err)  observe(32'h400);
      if (done || err) check("done_err_excl", int'(done && err), 0);
      prev_hold = busy && DATA_OE && !STP && !(NXT && !DIR);
      prev_out  = DATA_OUT;
    end
  end

  // Inputs set here are sampled at the next rising edge; oe/busy reflect the previous step.
  task automatic step(input logic d, input logic n, input bit noise);
    @(posedge clk);
    #1;
    oe_seen   = DATA_OE;
    busy_seen = busy;
    DIR = d;
    NXT = n;
    if (noise && $urandom_range(2) == 0) begin
      start = 1'b1;
      PID = 8'($urandom);
      D1  = 8'($urandom);
      D2  = 8'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                      input int kind, input int stop_stage, input int coll_in, input int w1_in);
    int coll, w, z, stop_at;
    bit ended;
    repeat (2 + $urandom_range(2)) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    DIR = 1'b0; NXT = 1'b0; PID = p; D1 = a; D2 = b; start = 1'b1;
    push_pkt(p, a, b, kind, stop_stage);
    stop_at = (kind == 0) ? 3 : stop_stage;
    for (int s = 0; s < 3; s++) begin
      if (s == stop_at) begin
        if (kind == 1) begin
          repeat ($urandom_range(3)) step(1'b0, 1'b0, 1'b1);
          repeat (1 + $urandom_range(2)) step(1'b1, 1'($urandom_range(1)), 1'b0);
          step(1'b0, 1'b0, 1'b0);
        end else begin
          repeat (TMO) step(1'b0, 1'b0, 1'b0);
        end
        break;
      end
      coll = 0;
      if (s == 0) coll = (coll_in >= 0) ? coll_in : (($urandom_range(2) == 0) ? 1 + $urandom_range(3) : 0);
      w = (s == 1 && w1_in >= 0) ? w1_in : $urandom_range(3);
      if (coll > 0) begin
        z = 0;
        for (int i = 0; i < coll; i++) begin
          step(1'b1, 1'($urandom_range(1)), 1'b0);
          if (i > 0) z += int'(!oe_seen);
        end
        step(1'b0, 1'($urandom_range(1)), 1'b0);
        z += int'(!oe_seen);
        step(1'b0, 1'b0, 1'b0);
        z += int'(!oe_seen);
        check("collision_oe_low_cycles", z, coll + 1);
        w = $urandom_range(1);
      end
      repeat (w) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end
    ended = 1'b0;
    for (int i = 0; i < 12 && !ended; i++) begin
      step(1'b0, 1'b0, 1'b0);
      ended = !busy_seen;
    end
    if (!ended) begin
      n_checks++;
      n_fail++;
      $display("FAIL packet_end_timeout: busy still %0d, expected 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    int kind, stg;
    #1 rst = 1'b0;
    #2;
    check("reset_data_out", int'(DATA_OUT), 0);
    check("reset_data_oe", int'(DATA_OE), 1);
    check("reset_stp", int'(STP), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    @(posedge clk);
    #3 rst = 1'b1;

    send(8'hC3, 8'h41, 8'h42, 0, 0, 0, 0);  // nominal packet
    send(8'hC3, 8'h41, 8'h42, 0, 0, 0, 3);  // slow PHY on D1
    send(8'hC3, 8'h41, 8'h42, 0, 0, 4, 0);  // TX CMD collision
    send(8'hC3, 8'h41, 8'h42, 1, 2, 0, 0);  // PHY abort in D2
    send(8'hC3, 8'h41, 8'h42, 2, 0, 0, 0);  // timeout in TX CMD
    send(8'h5A, 8'hA5, 8'h3C, 2, 2, 0, 0);  // timeout in D2

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(9);
      kind = (kind < 6) ? 0 : ((kind < 8) ? 1 : 2);
      stg  = (kind == 1) ? 1 + $urandom_range(1) : $urandom_range(2);
      send(8'($urandom), 8'($urandom), 8'($urandom), kind, stg, -1, -1);
    end

    // Reset in the middle of BYTE1
    repeat (2) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    PID = 8'h17; D1 = 8'h99; D2 = 8'h66; start = 1'b1;
    push_pkt(8'h17, 8'h99, 8'h66, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_data_out", int'(DATA_OUT), 0);
    check("midrst_data_oe", int'(DATA_OE), 1);
    check("midrst_stp", int'(STP), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_txcmd_seen", expq.size(), 4);
    expq.delete();
    NXT = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    send(8'h2E, 8'h01, 8'h02, 0, 0, 0, 0);

    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
